// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter for the 16x16 register file: merges ALU results and load returns onto one write port.
// Optional build macro ZERO_REG_GUARD_EN makes register 0 unwritable and invisible to the hazard query.
module reg_wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          Clear,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_addr,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          mem_valid,
    input  logic [ADDR_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_data,
    output logic                          mem_ready,
    output logic [DATA_W-1:0]             C,
    output logic [ADDR_W-1:0]             Caddr,
    output logic                          Load,
    output logic [$clog2(FIFO_DEPTH):0]   pend_count,
    input  logic [ADDR_W-1:0]             qry_addr,
    output logic                          qry_hit,
    output logic                          err_ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef ZERO_REG_GUARD_EN
    localparam bit ZERO_GUARD = 1'b1;
`else
    localparam bit ZERO_GUARD = 1'b0;
`endif

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld;
    logic [FIFO_DEPTH-1:0] fifo_kill;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic fifo_empty;
    logic pop;
    logic bypass;
    logic mem_zero;
    logic push;
    logic ovf;
    logic wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign fifo_empty = (pend_count == '0);
    assign mem_ready  = (pend_count < CNT_W'(FIFO_DEPTH));
    assign pop        = !alu_valid && !fifo_empty;
    assign bypass     = !alu_valid && fifo_empty && mem_valid;
    assign mem_zero   = ZERO_GUARD && (mem_addr == '0);
    assign push       = mem_valid && !bypass && mem_ready && !mem_zero;
    assign ovf        = mem_valid && !bypass && !mem_ready && !mem_zero;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = alu_addr;
        wr_data = alu_data;
        if (alu_valid) begin
            wr_en = 1'b1;
        end else if (pop) begin
            wr_en   = !fifo_kill[rd_ptr];
            wr_addr = fifo_addr[rd_ptr];
            wr_data = fifo_data[rd_ptr];
        end else if (mem_valid) begin
            wr_en   = 1'b1;
            wr_addr = mem_addr;
            wr_data = mem_data;
        end
        if (ZERO_GUARD && (wr_addr == '0)) wr_en = 1'b0;
    end

    // Killed entries are stale (an ALU write to the same register superseded them).
    always_comb begin
        qry_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i] && !fifo_kill[i] && (fifo_addr[i] == qry_addr)) qry_hit = 1'b1;
        end
        if (Load && (Caddr == qry_addr)) qry_hit = 1'b1;
        if (ZERO_GUARD && (qry_addr == '0)) qry_hit = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Clear) begin
            Load       <= 1'b0;
            C          <= '0;
            Caddr      <= '0;
            err_ovf    <= 1'b0;
            pend_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_vld   <= '0;
            fifo_kill  <= '0;
        end else begin
            Load <= wr_en;
            if (wr_en) begin
                C     <= wr_data;
                Caddr <= wr_addr;
            end
            if (ovf) err_ovf <= 1'b1;

            // Only entries already present are killed; the slot being pushed is not yet valid.
            if (alu_valid) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (fifo_vld[i] && (fifo_addr[i] == alu_addr)) fifo_kill[i] <= 1'b1;
                end
            end
            if (pop) begin
                fifo_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                fifo_vld[wr_ptr]  <= 1'b1;
                fifo_kill[wr_ptr] <= 1'b0;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end

            unique case ({push, pop})
                2'b10:   pend_count <= pend_count + CNT_W'(1);
                2'b01:   pend_count <= pend_count - CNT_W'(1);
                default: pend_count <= pend_count;
            endcase
        end
    end

    // NOTE: payload storage has no reset; validity is tracked by fifo_vld, which is reset.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mem_addr;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: expected register writes are queued as stimulus is driven
// and popped by a monitor whenever the write port fires.
module tb_reg_wb_arbiter;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 4;
    localparam int FIFO_DEPTH = 4;

    logic              Clk;
    logic              Clear;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic [DATA_W-1:0] C;
    logic [ADDR_W-1:0] Caddr;
    logic              Load;
    logic [2:0]        pend_count;
    logic [ADDR_W-1:0] qry_addr;
    logic              qry_hit;
    logic              err_ovf;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    reg_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .Clk(Clk), .Clear(Clear),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready), .C(C), .Caddr(Caddr), .Load(Load),
        .pend_count(pend_count), .qry_addr(qry_addr), .qry_hit(qry_hit),
        .err_ovf(err_ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        alu_valid = v;
        alu_addr  = a;
        alu_data  = d;
    endtask

    task automatic set_mem(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mem_valid = v;
        mem_addr  = a;
        mem_data  = d;
    endtask

    task automatic idle();
        set_alu(1'b0, '0, '0);
        set_mem(1'b0, '0, '0);
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic query(input string tag, input logic [ADDR_W-1:0] a, input logic exp);
        qry_addr = a;
        #1;
        check(tag, 32'(qry_hit), 32'(exp));
    endtask

    // Scoreboard side: every write-port assertion must match the oldest expected write.
    always @(negedge Clk) begin
        if (Load === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {12'h0, Caddr, C}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wb_addr", 32'(Caddr), 32'(e.addr));
                check("wb_data", 32'(C), 32'(e.data));
            end
        end
    end

    initial begin
        // Reset held for two edges with both sources requesting.
        Clear    = 1'b0;
        qry_addr = '0;
        set_alu(1'b1, 4'd7, 16'h0077);
        set_mem(1'b1, 4'd9, 16'h0099);
        cyc();
        cyc();
        check("rst_load", 32'(Load), 32'd0);
        check("rst_c", 32'(C), 32'd0);
        check("rst_caddr", 32'(Caddr), 32'd0);
        check("rst_pend", 32'(pend_count), 32'd0);
        check("rst_ovf", 32'(err_ovf), 32'd0);
        Clear = 1'b1;
        idle();
        cyc();
        check("rst_ready", 32'(mem_ready), 32'd1);
        check("rst_idle_load", 32'(Load), 32'd0);

        // Bypass with empty FIFO.
        set_mem(1'b1, 4'd3, 16'h0005);
        expect_wr(4'd3, 16'h0005);
        cyc();
        idle();
        check("byp_load", 32'(Load), 32'd1);
        check("byp_pend", 32'(pend_count), 32'd0);
        query("byp_qry3", 4'd3, 1'b1);
        cyc();

        // Collision then drain.
        set_alu(1'b1, 4'd1, 16'h0006);
        set_mem(1'b1, 4'd2, 16'h0007);
        expect_wr(4'd1, 16'h0006);
        expect_wr(4'd2, 16'h0007);
        cyc();
        idle();
        check("col_load", 32'(Load), 32'd1);
        check("col_caddr", 32'(Caddr), 32'd1);
        check("col_pend", 32'(pend_count), 32'd1);
        query("col_qry2", 4'd2, 1'b1);
        cyc();
        check("drn_caddr", 32'(Caddr), 32'd2);
        check("drn_pend", 32'(pend_count), 32'd0);
        cyc();
        check("hold_load", 32'(Load), 32'd0);
        check("hold_c", 32'(C), 32'h0007);
        check("hold_caddr", 32'(Caddr), 32'd2);

        // WAW kill of an older buffered load.
        set_alu(1'b1, 4'd5, 16'h0055);
        set_mem(1'b1, 4'd4, 16'hAAAA);
        expect_wr(4'd5, 16'h0055);
        cyc();
        check("waw_pend", 32'(pend_count), 32'd1);
        set_alu(1'b1, 4'd4, 16'h1111);
        set_mem(1'b0, '0, '0);
        expect_wr(4'd4, 16'h1111);
        cyc();
        idle();
        check("waw_c", 32'(C), 32'h1111);
        query("waw_qry_inflight", 4'd4, 1'b1);
        cyc();
        check("waw_kill_load", 32'(Load), 32'd0);
        check("waw_kill_pend", 32'(pend_count), 32'd0);
        check("waw_kill_hold_c", 32'(C), 32'h1111);
        query("waw_qry_after", 4'd4, 1'b0);

        // Same-cycle push is newer than the ALU write and survives.
        set_alu(1'b1, 4'd6, 16'h0066);
        set_mem(1'b1, 4'd6, 16'h6666);
        expect_wr(4'd6, 16'h0066);
        expect_wr(4'd6, 16'h6666);
        cyc();
        idle();
        check("newer_pend", 32'(pend_count), 32'd1);
        query("newer_qry6", 4'd6, 1'b1);
        cyc();
        check("newer_load", 32'(Load), 32'd1);
        check("newer_c", 32'(C), 32'h6666);

        // Fill to full and overflow while the ALU is busy.
        for (int i = 0; i < 5; i++) begin
            set_alu(1'b1, 4'd15, 16'(16'h0100 + i));
            set_mem(1'b1, 4'(8 + i), 16'(16'h0B00 + i));
            expect_wr(4'd15, 16'(16'h0100 + i));
            if (i == 4) begin
                check("full_pend", 32'(pend_count), 32'd4);
                check("full_ready", 32'(mem_ready), 32'd0);
                check("pre_ovf", 32'(err_ovf), 32'd0);
            end
            cyc();
        end
        check("ovf_set", 32'(err_ovf), 32'd1);
        check("ovf_pend", 32'(pend_count), 32'd4);
        for (int i = 0; i < 4; i++) expect_wr(4'(8 + i), 16'(16'h0B00 + i));
        expect_wr(4'd14, 16'h000E);
        // A pop while full does not free a slot for a same-cycle load.
        set_alu(1'b0, '0, '0);
        set_mem(1'b1, 4'd13, 16'h000D);
        cyc();
        check("full_pop_pend", 32'(pend_count), 32'd3);
        set_mem(1'b1, 4'd14, 16'h000E);
        cyc();
        check("pop_push_pend", 32'(pend_count), 32'd3);
        idle();
        cyc();
        cyc();
        cyc();
        check("ovf_drained", 32'(pend_count), 32'd0);
        check("ovf_sticky", 32'(err_ovf), 32'd1);
        cyc();

        // Register 0 write.
        set_alu(1'b1, 4'd0, 16'h0009);
`ifndef ZERO_REG_GUARD_EN
        expect_wr(4'd0, 16'h0009);
`endif
        cyc();
        idle();
`ifdef ZERO_REG_GUARD_EN
        check("zero_load", 32'(Load), 32'd0);
        query("zero_qry", 4'd0, 1'b0);
`else
        check("zero_load", 32'(Load), 32'd1);
        check("zero_caddr", 32'(Caddr), 32'd0);
        query("zero_qry", 4'd0, 1'b1);
`endif
        cyc();

        // Reset mid-operation discards buffered loads.
        set_alu(1'b1, 4'd1, 16'h0021);
        set_mem(1'b1, 4'd2, 16'h0022);
        expect_wr(4'd1, 16'h0021);
        cyc();
        set_alu(1'b1, 4'd1, 16'h0023);
        set_mem(1'b1, 4'd3, 16'h0024);
        expect_wr(4'd1, 16'h0023);
        cyc();
        check("mid_pend", 32'(pend_count), 32'd2);
        idle();
        Clear = 1'b0;
        cyc();
        Clear = 1'b1;
        check("mid_rst_pend", 32'(pend_count), 32'd0);
        check("mid_rst_ovf", 32'(err_ovf), 32'd0);
        check("mid_rst_load", 32'(Load), 32'd0);
        cyc();
        cyc();
        check("mid_rst_nowrite", 32'(Load), 32'd0);
        check("mid_rst_ready", 32'(mem_ready), 32'd1);
        cyc();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
